fxp_mul_pipe: RTL and testbench

- Parametrised signed fixed-point multiplier with a configurable pipeline depth and valid/ready flow control on both sides.
- Per-sample selectable rounding and saturation; provides the full-precision product and a narrowed output with an overflow flag.
- Successor to the fixed Q0.15 single-multiplier path. Used in the attention/MAC datapath wherever a Qm.n x Qm.n product must be returned to working precision.

---
 rtl/fxp_mul_pipe.sv | 92 +++++++++
 tb/tb_fxp_mul_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mul_pipe.sv
// Signed fixed-point multiplier, STAGES-deep pipeline with valid/ready on both sides.
// Returns the exact product and a rounded, optionally saturated product narrowed to OUT_W bits.
module fxp_mul_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15,
  parameter int OUT_W  = 16,
  parameter int STAGES = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic                  round_en,
  input  logic                  sat_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   full_out,
  output logic [OUT_W-1:0]      q_out,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int PW = 2*DATA_W;
  localparam logic signed [PW:0] HALF = (PW+1)'(1) << (FRAC_W-1);

  typedef struct packed {
    logic [PW-1:0] p;
    logic          rnd;
    logic          sat;
  } smp_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            advance;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];

  // Sign-extend before multiplying so the most-negative square stays exact.
  logic signed [PW-1:0] prod;
  smp_t                 s_in, s_last;

  assign prod = PW'($signed(a)) * PW'($signed(b));
  assign s_in = '{p: prod, rnd: round_en, sat: sat_en};

  generate
    if (STAGES == 1) begin : g_s1
      assign s_last = s_in;
    end else begin : g_sn
      smp_t pipe_q [STAGES-1];
      always_ff @(posedge clk)
        if (advance) begin
          pipe_q[0] <= s_in;
          for (int i = 1; i < STAGES-1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign s_last = pipe_q[STAGES-2];
    end
  endgenerate

  // Round/narrow in the final stage; one guard bit keeps the +half from wrapping.
  logic signed [PW:0]  r_c, s_c;
  logic                ovf_c;
  logic [OUT_W-1:0]    q_c;

  always_comb begin
    r_c = $signed({s_last.p[PW-1], s_last.p});
    if (s_last.rnd) r_c = r_c + HALF;
    s_c   = r_c >>> FRAC_W;
    ovf_c = !((&s_c[PW:OUT_W-1]) || !(|s_c[PW:OUT_W-1]));
    q_c   = s_c[OUT_W-1:0];
    if (ovf_c && s_last.sat)
      q_c = s_c[PW] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Only real samples load the outputs, so bubbles never disturb them.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_out <= '0;
      q_out    <= '0;
      ovf      <= 1'b0;
    end else if (advance && vld_pipe[STAGES-1]) begin
      full_out <= s_last.p;
      q_out    <= q_c;
      ovf      <= ovf_c;
    end
endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Directed checks of fxp_mul_pipe at depths 1, 2 and 4 (Q0.15 defaults).
module tb_fxp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic round_en = 1'b0, sat_en = 1'b0;
  logic [2:0] in_valid_v = '0, in_ready_v, out_valid_v, ovf_v;
  logic [2:0] out_ready_v = 3'b111;
  logic [2:0][31:0] full_v;
  logic [2:0][15:0] q_v;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fxp_mul_pipe #(.DATA_W(16), .FRAC_W(15), .OUT_W(16), .STAGES(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .round_en(round_en), .sat_en(sat_en),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]), .full_out(full_v[g]),
      .q_out(q_v[g]), .ovf(ovf_v[g]), .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]));
  end

  typedef struct { logic [31:0] f; logic [15:0] q; logic o; } exp_t;

  function automatic exp_t ref_model(input logic [15:0] ta, input logic [15:0] tb_,
                                     input logic tr, input logic ts);
    exp_t e;
    longint p, s;
    p = longint'($signed(ta)) * longint'($signed(tb_));
    s = (p + (tr ? 64'sd16384 : 64'sd0)) >>> 15;
    e.f = p[31:0];
    e.o = (s > 32767) || (s < -32768);
    e.q = (ts && e.o) ? ((s < 0) ? 16'h8000 : 16'h7FFF) : s[15:0];
    return e;
  endfunction

  task automatic send_and_wait(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tr, input logic ts, output exp_t got, output int lat);
    @(negedge clk);
    a = ta; b = tb_; round_en = tr; sat_en = ts;
    in_valid_v = '0; in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v = '0;
    lat = 1;
    while (!out_valid_v[k] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    got.f = full_v[k]; got.q = q_v[k]; got.o = ovf_v[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid_v, ovf_v} !== 6'b0 || full_v !== '0 || q_v !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b ovf=%b full=%h q=%h exp all zero",
               out_valid_v, ovf_v, full_v, q_v);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready_v !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=111", in_ready_v);
    end
  endtask

  task automatic test_basic();
    exp_t got; int lat;
    for (int k = 0; k < 3; k++) begin
      send_and_wait(k, 16'h4000, 16'h4000, 1'b0, 1'b1, got, lat);
      checks++;
      if (lat !== (1 << k) || got.f !== 32'h1000_0000 || got.q !== 16'h2000 || got.o !== 1'b0) begin
        errors++;
        $display("FAIL half_sq dut=%0d got lat=%0d f=%h q=%h o=%b exp lat=%0d f=10000000 q=2000 o=0",
                 k, lat, got.f, got.q, got.o, 1 << k);
      end
    end
  endtask

  task automatic test_sat();
    exp_t got; int lat;
    for (int k = 0; k < 3; k++) begin
      send_and_wait(k, 16'h8000, 16'h8000, 1'b0, 1'b1, got, lat);
      checks++;
      if (got.f !== 32'h4000_0000 || got.q !== 16'h7FFF || got.o !== 1'b1) begin
        errors++;
        $display("FAIL neg1_sat dut=%0d got f=%h q=%h o=%b exp f=40000000 q=7fff o=1",
                 k, got.f, got.q, got.o);
      end
      send_and_wait(k, 16'h8000, 16'h8000, 1'b0, 1'b0, got, lat);
      checks++;
      if (got.f !== 32'h4000_0000 || got.q !== 16'h8000 || got.o !== 1'b1) begin
        errors++;
        $display("FAIL neg1_wrap dut=%0d got f=%h q=%h o=%b exp f=40000000 q=8000 o=1",
                 k, got.f, got.q, got.o);
      end
    end
  endtask

  task automatic test_round();
    logic [15:0] va [4] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic        vr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ef [4] = '{32'h0000_4000, 32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_C000};
    logic [15:0] eq [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
    exp_t got; int lat;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        send_and_wait(k, va[i], 16'h4000, vr[i], 1'b1, got, lat);
        checks++;
        if (got.f !== ef[i] || got.q !== eq[i] || got.o !== 1'b0) begin
          errors++;
          $display("FAIL round_%0d dut=%0d got f=%h q=%h o=%b exp f=%h q=%h o=0",
                   i, k, got.f, got.q, got.o, ef[i], eq[i]);
        end
      end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      exp_t exp_q [$];
      exp_t e;
      logic [15:0] sa [8], sb [8];
      logic sr [8], ss [8];
      int sent = 0, rcvd = 0, cyc = 0;
      logic was_stalled = 1'b0;
      logic [31:0] hf; logic [15:0] hq; logic ho;
      for (int i = 0; i < 8; i++) begin
        sa[i] = 16'($urandom); sb[i] = 16'($urandom);
        sr[i] = 1'($urandom); ss[i] = 1'($urandom);
      end
      sa[3] = 16'h8000; sb[3] = 16'h8000;
      while (rcvd < 8 && cyc < 80) begin
        @(negedge clk);
        out_ready_v[k] = !(cyc >= 4 && cyc < 9);
        in_valid_v = '0;
        if (sent < 8) begin
          a = sa[sent]; b = sb[sent]; round_en = sr[sent]; sat_en = ss[sent];
          in_valid_v[k] = 1'b1;
        end
        #1;
        if (was_stalled) begin
          checks++;
          if (!out_valid_v[k] || full_v[k] !== hf || q_v[k] !== hq || ovf_v[k] !== ho) begin
            errors++;
            $display("FAIL bp_hold dut=%0d cyc=%0d got v=%b f=%h q=%h o=%b exp v=1 f=%h q=%h o=%b",
                     k, cyc, out_valid_v[k], full_v[k], q_v[k], ovf_v[k], hf, hq, ho);
          end
        end
        was_stalled = out_valid_v[k] && !out_ready_v[k];
        hf = full_v[k]; hq = q_v[k]; ho = ovf_v[k];
        if (was_stalled) begin
          checks++;
          if (in_ready_v[k] !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready dut=%0d cyc=%0d got=%b exp=0", k, cyc, in_ready_v[k]);
          end
        end
        if (out_valid_v[k] && out_ready_v[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL bp_extra dut=%0d cyc=%0d got unexpected output exp none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (full_v[k] !== e.f || q_v[k] !== e.q || ovf_v[k] !== e.o) begin
              errors++;
              $display("FAIL bp_data dut=%0d n=%0d got f=%h q=%h o=%b exp f=%h q=%h o=%b",
                       k, rcvd, full_v[k], q_v[k], ovf_v[k], e.f, e.q, e.o);
            end
          end
          rcvd++;
        end
        if (in_valid_v[k] && in_ready_v[k]) begin
          exp_q.push_back(ref_model(sa[sent], sb[sent], sr[sent], ss[sent]));
          sent++;
        end
        @(posedge clk);
        cyc++;
      end
      @(negedge clk);
      in_valid_v = '0; out_ready_v = 3'b111;
      checks++;
      if (rcvd !== 8 || exp_q.size() !== 0) begin
        errors++;
        $display("FAIL bp_count dut=%0d got rcvd=%0d pending=%0d exp rcvd=8 pending=0", k, rcvd, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got; int lat;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h7FFF; round_en = 1'b1; sat_en = 1'b1; in_valid_v = 3'b111;
    @(posedge clk);
    @(negedge clk);
    a = 16'h8000; b = 16'h4000;
    @(posedge clk); #1;
    in_valid_v = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_v, ovf_v} !== 6'b0 || full_v !== '0 || q_v !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ovf=%b full=%h q=%h exp all zero",
               out_valid_v, ovf_v, full_v, q_v);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_and_wait(k, 16'hC000, 16'h6000, 1'b0, 1'b1, got, lat);
      checks++;
      if (lat !== (1 << k) || got.f !== 32'hE800_0000 || got.q !== 16'hD000 || got.o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset dut=%0d got lat=%0d f=%h q=%h o=%b exp lat=%0d f=e8000000 q=d000 o=0",
                 k, lat, got.f, got.q, got.o, 1 << k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_round();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
